// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer for the DDS core: steps freq_ctrl between two endpoints
// with a programmable dwell, in single, repeating or triangle mode.
module dds_sweep_ctrl #(
  parameter int FREQ_BIT  = 26,
  parameter int DWELL_BIT = 24,
  parameter int FREQ_MAX  = 50_000_000
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [FREQ_BIT-1:0]  cfg_f_start,
  input  logic [FREQ_BIT-1:0]  cfg_f_stop,
  input  logic [FREQ_BIT-1:0]  cfg_f_step,
  input  logic [DWELL_BIT-1:0] cfg_dwell,
  input  logic [1:0]           cfg_mode,
  input  logic [1:0]           cfg_wav,
  input  logic [8:0]           cfg_phase,
  output logic [FREQ_BIT-1:0]  freq_ctrl,
  output logic [8:0]           phase_ctrl,
  output logic [1:0]           wav_select,
  output logic                 dds_en,
  output logic                 busy,
  output logic                 step_tick,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0]          MODE_SINGLE = 2'd0;
  localparam logic [1:0]          MODE_REPEAT = 2'd1;
  localparam logic [1:0]          MODE_TRI    = 2'd2;
  localparam logic [1:0]          MODE_RSVD   = 2'd3;
  localparam logic [FREQ_BIT-1:0] F_MAX       = FREQ_BIT'(FREQ_MAX);

  // One step from cur toward tgt; the signed guard bits keep the sum from wrapping
  // so the result saturates exactly at the endpoint.
  function automatic logic [FREQ_BIT-1:0] step_clamp(
    input logic [FREQ_BIT-1:0] cur,
    input logic [FREQ_BIT-1:0] stp,
    input logic [FREQ_BIT-1:0] tgt,
    input logic                up
  );
    logic signed [FREQ_BIT+1:0] c, s, t, n;
    c = $signed({2'b00, cur});
    s = $signed({2'b00, stp});
    t = $signed({2'b00, tgt});
    n = up ? (c + s) : (c - s);
    if (up ? (n > t) : (n < t)) step_clamp = tgt;
    else                        step_clamp = n[FREQ_BIT-1:0];
  endfunction

  state_t               state, state_nxt;
  logic [FREQ_BIT-1:0]  freq_nxt;
  logic [8:0]           phase_nxt;
  logic [1:0]           wav_nxt;
  logic                 en_nxt, busy_nxt, tick_nxt, done_nxt, err_nxt;
  logic [DWELL_BIT-1:0] dwell_cnt, cnt_nxt;
  logic                 dir_up, dir_nxt;
  logic                 tgt_stop, tgt_stop_nxt;

  logic [FREQ_BIT-1:0]  f_start_r, f_stop_r, f_step_r;
  logic [DWELL_BIT-1:0] dwell_last;
  logic [1:0]           mode_r;

  logic                 cfg_bad, start_ok;
  logic [FREQ_BIT-1:0]  target, tri_tgt;

  assign cfg_bad  = ((cfg_f_step == '0) && (cfg_f_start != cfg_f_stop)) ||
                    (cfg_f_start > F_MAX) || (cfg_f_stop > F_MAX) ||
                    (cfg_phase > 9'd359) || (cfg_mode == MODE_RSVD);
  assign start_ok = (state == IDLE) && start && !stop && !cfg_bad;
  assign target   = tgt_stop ? f_stop_r : f_start_r;
  assign tri_tgt  = tgt_stop ? f_start_r : f_stop_r;

  always_comb begin
    state_nxt    = state;
    freq_nxt     = freq_ctrl;
    phase_nxt    = phase_ctrl;
    wav_nxt      = wav_select;
    en_nxt       = 1'b0;
    busy_nxt     = 1'b0;
    tick_nxt     = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    cnt_nxt      = dwell_cnt;
    dir_nxt      = dir_up;
    tgt_stop_nxt = tgt_stop;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (cfg_bad) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt    = RUN;
            freq_nxt     = cfg_f_start;
            phase_nxt    = cfg_phase;
            wav_nxt      = cfg_wav;
            en_nxt       = 1'b1;
            busy_nxt     = 1'b1;
            tick_nxt     = 1'b1;
            cnt_nxt      = '0;
            dir_nxt      = (cfg_f_stop >= cfg_f_start);
            tgt_stop_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          en_nxt   = 1'b1;
          busy_nxt = 1'b1;
          if (dwell_cnt == dwell_last) begin
            cnt_nxt = '0;
            if (freq_ctrl != target) begin
              freq_nxt = step_clamp(freq_ctrl, f_step_r, target, dir_up);
              tick_nxt = 1'b1;
            end else begin
              case (mode_r)
                MODE_REPEAT: begin
                  freq_nxt = f_start_r;
                  tick_nxt = 1'b1;
                end
                MODE_TRI: begin
                  dir_nxt      = !dir_up;
                  tgt_stop_nxt = !tgt_stop;
                  freq_nxt     = step_clamp(freq_ctrl, f_step_r, tri_tgt, !dir_up);
                  tick_nxt     = 1'b1;
                end
                default: begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  en_nxt    = 1'b0;
                  busy_nxt  = 1'b0;
                end
              endcase
            end
          end else begin
            cnt_nxt = dwell_cnt + DWELL_BIT'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and control state
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      freq_ctrl  <= '0;
      phase_ctrl <= '0;
      wav_select <= '0;
      dds_en     <= 1'b0;
      busy       <= 1'b0;
      step_tick  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dwell_cnt  <= '0;
      dir_up     <= 1'b1;
      tgt_stop   <= 1'b1;
    end else begin
      state      <= state_nxt;
      freq_ctrl  <= freq_nxt;
      phase_ctrl <= phase_nxt;
      wav_select <= wav_nxt;
      dds_en     <= en_nxt;
      busy       <= busy_nxt;
      step_tick  <= tick_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      dwell_cnt  <= cnt_nxt;
      dir_up     <= dir_nxt;
      tgt_stop   <= tgt_stop_nxt;
    end
  end

  // Sweep configuration snapshot, taken only on an accepted start
  always_ff @(posedge sclk) begin
    if (start_ok) begin
      f_start_r  <= cfg_f_start;
      f_stop_r   <= cfg_f_stop;
      f_step_r   <= cfg_f_step;
      mode_r     <= cfg_mode;
      dwell_last <= (cfg_dwell == '0) ? '0 : (cfg_dwell - DWELL_BIT'(1));
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: expected per-cycle outputs are queued as each
// stimulus cycle is driven and compared one cycle later.
module tb_dds_sweep_ctrl;
  localparam int FB = 26;
  localparam int DB = 24;

  logic          sclk = 1'b0;
  logic          rst_n, start, stop;
  logic [FB-1:0] cfg_f_start, cfg_f_stop, cfg_f_step;
  logic [DB-1:0] cfg_dwell;
  logic [1:0]    cfg_mode, cfg_wav;
  logic [8:0]    cfg_phase;
  logic [FB-1:0] freq_ctrl;
  logic [8:0]    phase_ctrl;
  logic [1:0]    wav_select;
  logic          dds_en, busy, step_tick, done, err;

  always #5 sclk = ~sclk;

  dds_sweep_ctrl #(.FREQ_BIT(FB), .DWELL_BIT(DB), .FREQ_MAX(50_000_000)) dut (
    .sclk(sclk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_wav(cfg_wav), .cfg_phase(cfg_phase),
    .freq_ctrl(freq_ctrl), .phase_ctrl(phase_ctrl), .wav_select(wav_select),
    .dds_en(dds_en), .busy(busy), .step_tick(step_tick), .done(done), .err(err)
  );

  typedef struct packed {
    logic [FB-1:0] f;
    logic [8:0]    ph;
    logic [1:0]    wv;
    logic [4:0]    fl;
  } exp_t;

  // flag vector order: {dds_en, busy, step_tick, done, err}
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_RUNT = 5'b11100;
  localparam logic [4:0] F_RUN  = 5'b11000;
  localparam logic [4:0] F_DONE = 5'b00010;
  localparam logic [4:0] F_ERR  = 5'b00001;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_ph;
  logic [1:0] exp_wv;
  string      tag;

  task automatic cyc(input logic [FB-1:0] f, input logic [4:0] fl);
    exp_t e;
    logic [4:0] got_fl;
    e.f = f; e.ph = exp_ph; e.wv = exp_wv; e.fl = fl;
    sb.push_back(e);
    @(posedge sclk);
    #1;
    e = sb.pop_front();
    got_fl = {dds_en, busy, step_tick, done, err};
    checks++;
    assert (freq_ctrl === e.f) else begin
      failures++;
      $error("FAIL %s freq_ctrl got=%0d exp=%0d", tag, freq_ctrl, e.f);
    end
    checks++;
    assert (got_fl === e.fl) else begin
      failures++;
      $error("FAIL %s flags{en,busy,tick,done,err} got=%b exp=%b", tag, got_fl, e.fl);
    end
    checks++;
    assert ({phase_ctrl, wav_select} === {e.ph, e.wv}) else begin
      failures++;
      $error("FAIL %s phase/wav got=%0d/%0d exp=%0d/%0d", tag, phase_ctrl, wav_select, e.ph, e.wv);
    end
  endtask

  task automatic dwell(input logic [FB-1:0] f, input int n);
    cyc(f, F_RUNT);
    repeat (n - 1) cyc(f, F_RUN);
  endtask

  task automatic set_cfg(input logic [FB-1:0] fs, input logic [FB-1:0] fe, input logic [FB-1:0] st,
                         input logic [DB-1:0] dw, input logic [1:0] md, input logic [1:0] wv,
                         input logic [8:0] ph);
    cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st;
    cfg_dwell = dw; cfg_mode = md; cfg_wav = wv; cfg_phase = ph;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    exp_ph = 0; exp_wv = 0;
    repeat (2) @(posedge sclk);
    #1;
    tag = "reset";
    cyc(0, F_IDLE);
    rst_n = 1'b1;
    cyc(0, F_IDLE);

    tag = "single_up";
    set_cfg(1000, 1250, 100, 3, 0, 1, 45);
    exp_ph = 45; exp_wv = 1;
    start = 1'b1;
    cyc(1000, F_RUNT);
    start = 1'b0;
    cyc(1000, F_RUN);
    tag = "start_busy";
    cfg_f_start = 5000; cfg_phase = 200;
    start = 1'b1;
    cyc(1000, F_RUN);
    start = 1'b0;
    tag = "single_up";
    dwell(1100, 3);
    dwell(1200, 3);
    dwell(1250, 3);
    cyc(1250, F_DONE);
    cyc(1250, F_IDLE);

    tag = "triangle";
    set_cfg(500, 700, 100, 1, 2, 2, 90);
    exp_ph = 90; exp_wv = 2;
    start = 1'b1;
    cyc(500, F_RUNT);
    start = 1'b0;
    cyc(600, F_RUNT); cyc(700, F_RUNT); cyc(600, F_RUNT); cyc(500, F_RUNT);
    cyc(600, F_RUNT); cyc(700, F_RUNT); cyc(600, F_RUNT);
    tag = "tri_stop";
    stop = 1'b1;
    cyc(600, F_IDLE);
    stop = 1'b0;
    cyc(600, F_IDLE);

    tag = "repeat_down";
    set_cfg(300, 100, 100, 2, 1, 3, 0);
    exp_ph = 0; exp_wv = 3;
    start = 1'b1;
    cyc(300, F_RUNT);
    start = 1'b0;
    cyc(300, F_RUN);
    dwell(200, 2);
    dwell(100, 2);
    dwell(300, 2);
    cyc(200, F_RUNT);
    stop = 1'b1;
    cyc(200, F_IDLE);
    stop = 1'b0;

    tag = "dwell0";
    set_cfg(100, 300, 100, 0, 1, 0, 359);
    exp_ph = 359; exp_wv = 0;
    start = 1'b1;
    cyc(100, F_RUNT);
    start = 1'b0;
    cyc(200, F_RUNT); cyc(300, F_RUNT); cyc(100, F_RUNT); cyc(200, F_RUNT);
    stop = 1'b1;
    cyc(200, F_IDLE);
    stop = 1'b0;

    tag = "rej_phase";
    set_cfg(100, 300, 100, 1, 0, 1, 360);
    start = 1'b1; cyc(200, F_ERR); start = 1'b0; cyc(200, F_IDLE);
    tag = "rej_step0";
    set_cfg(100, 300, 0, 1, 0, 1, 10);
    start = 1'b1; cyc(200, F_ERR); start = 1'b0; cyc(200, F_IDLE);
    tag = "rej_fmax";
    set_cfg(100, 60_000_000, 100, 1, 0, 1, 10);
    start = 1'b1; cyc(200, F_ERR); start = 1'b0; cyc(200, F_IDLE);
    tag = "rej_mode3";
    set_cfg(100, 300, 100, 1, 3, 1, 10);
    start = 1'b1; cyc(200, F_ERR); start = 1'b0; cyc(200, F_IDLE);
    tag = "start_stop";
    set_cfg(100, 300, 100, 1, 0, 1, 10);
    start = 1'b1; stop = 1'b1; cyc(200, F_IDLE);
    start = 1'b0; stop = 1'b0; cyc(200, F_IDLE);

    tag = "clamp_fmax";
    set_cfg(49_999_900, 50_000_000, 300, 1, 0, 2, 1);
    exp_ph = 1; exp_wv = 2;
    start = 1'b1;
    cyc(49_999_900, F_RUNT);
    start = 1'b0;
    cyc(50_000_000, F_RUNT);
    cyc(50_000_000, F_DONE);
    cyc(50_000_000, F_IDLE);

    tag = "equal_ends";
    set_cfg(2000, 2000, 0, 5, 0, 1, 180);
    exp_ph = 180; exp_wv = 1;
    start = 1'b1;
    cyc(2000, F_RUNT);
    start = 1'b0;
    repeat (4) cyc(2000, F_RUN);
    cyc(2000, F_DONE);
    cyc(2000, F_IDLE);

    tag = "reset_mid";
    set_cfg(500, 700, 100, 1, 2, 2, 90);
    exp_ph = 90; exp_wv = 2;
    start = 1'b1;
    cyc(500, F_RUNT);
    start = 1'b0;
    cyc(600, F_RUNT);
    rst_n = 1'b0;
    exp_ph = 0; exp_wv = 0;
    cyc(0, F_IDLE);
    rst_n = 1'b1;
    cyc(0, F_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
